// File: rtl/rr_arbiter16_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
//   ARB_N       : number of requesters
//   ARB_W       : width of a requester index
//   arb_state_e : arbiter state (ARB_IDLE = no grant, ARB_BUSY = one grant held)
package rr_arbiter16_pkg;

    localparam int ARB_N = 16;
    localparam int ARB_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter16_enc.sv
// encoder16: one-hot to binary index encoder.
//   onehot_i : 16-bit one-hot vector (all-zero allowed)
//   idx_o    : binary index of the set bit; 0 when onehot_i is all-zero
module encoder16
    import rr_arbiter16_pkg::*;
(
    input  logic [ARB_N-1:0] onehot_i,
    output logic [ARB_W-1:0] idx_o
);

    // OR-reduction of the indices of set bits; exact for one-hot input and
    // naturally yields 0 for an empty vector.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (onehot_i[i]) idx_o = idx_o | ARB_W'(i);
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with grant hold, done/implicit
// release and an optional hold timeout.
//   TIMEOUT   : max cycles a grant is held (0 disables), 0..65535
//   clk       : rising-edge clock
//   resetn    : asynchronous active-low reset
//   req       : request vector, bit i = requester i
//   mask      : 1 = requester i ineligible for new grants
//   done      : current owner releases this cycle
//   gnt       : registered one-hot grant
//   gnt_idx   : binary index of gnt (0 when idle)
//   gnt_valid : a grant is held
//   timeout   : one-cycle pulse, grant was force-released by the hold timer
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ARB_N-1:0] req,
    input  logic [ARB_N-1:0] mask,
    input  logic             done,
    output logic [ARB_N-1:0] gnt,
    output logic [ARB_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int unsigned   TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [15:0]   TO_LAST = TO_M1[15:0];

    arb_state_e       state_q, state_d;
    logic [ARB_N-1:0] gnt_q, gnt_d;
    logic [ARB_W-1:0] ptr_q, ptr_d;
    logic [15:0]      hold_q, hold_d;
    logic             to_q, to_d;

    logic [ARB_N-1:0] elig;
    logic [ARB_N-1:0] win_idle;
    logic [ARB_N-1:0] win_rel;
    logic [ARB_W-1:0] nxt_ptr;
    logic             own_req;
    logic             to_hit;
    logic             rel;

    // Rotating-priority pick: rotate the vector so ptr sits at bit 0, isolate
    // the lowest set bit, then rotate the one-hot result back into place.
    function automatic logic [ARB_N-1:0] rr_pick(input logic [ARB_N-1:0] vec,
                                                 input logic [ARB_W-1:0] ptr);
        logic [2*ARB_N-1:0] dbl;
        logic [2*ARB_N-1:0] back;
        logic [ARB_N-1:0]   rot;
        logic [ARB_N-1:0]   oh;
        dbl  = {vec, vec} >> ptr;
        rot  = dbl[ARB_N-1:0];
        oh   = rot & (-rot);
        back = {oh, oh} << ptr;
        return back[2*ARB_N-1:ARB_N];
    endfunction

    encoder16 u_enc (
        .onehot_i (gnt_q),
        .idx_o    (gnt_idx)
    );

    assign elig     = req & ~mask;
    assign own_req  = |(req & gnt_q);
    assign to_hit   = (TIMEOUT != 0) && (hold_q == TO_LAST);
    assign rel      = done | ~own_req | to_hit;
    // Releasing owner becomes lowest priority for the handoff pick.
    assign nxt_ptr  = gnt_idx + ARB_W'(1);
    assign win_idle = rr_pick(elig, ptr_q);
    assign win_rel  = rr_pick(elig, nxt_ptr);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|elig) begin
                    gnt_d   = win_idle;
                    state_d = ARB_BUSY;
                    hold_d  = '0;
                end
            end
            ARB_BUSY: begin
                if (rel) begin
                    ptr_d = nxt_ptr;
                    // Pulse only when the timer alone forced the release.
                    to_d  = to_hit & ~done & own_req;
                    if (|win_rel) begin
                        gnt_d  = win_rel;
                        hold_d = '0;
                    end else begin
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (hold_q != 16'hFFFF) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] mask = '0;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter16 #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .mask      (mask),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (gnt !== 16'h0 || gnt_idx !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_outs: gnt=%h idx=%0d vld=%b to=%b want 0/0/0/0", gnt, gnt_idx, gnt_valid, timeout); end
        tick();
        resetn = 1'b1;
        tick();
        req = 16'h0008;
        #2;
        n_cmp++; if (gnt !== 16'h0) begin
            n_err++; $display("FAIL single_latency: gnt=%h want 0000", gnt); end
        tick();
        n_cmp++; if (gnt !== 16'h0008 || gnt_idx !== 4'd3 || gnt_valid !== 1'b1) begin
            n_err++; $display("FAIL single_gnt: gnt=%h idx=%0d vld=%b want 0008/3/1", gnt, gnt_idx, gnt_valid); end
        done = 1'b1;
        req  = 16'h0;
        tick();
        done = 1'b0;
        n_cmp++; if (gnt !== 16'h0 || gnt_valid !== 1'b0 || dut.ptr_q !== 4'd4) begin
            n_err++; $display("FAIL single_release: gnt=%h vld=%b ptr=%0d want 0000/0/4", gnt, gnt_valid, dut.ptr_q); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_seq [5];
        exp_seq = '{16'h0001, 16'h0010, 16'h8000, 16'h0001, 16'h0010};
        // restart priority at 0 so the sequence starts at requester 0
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        req = 16'h8011;
        tick();
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (gnt !== exp_seq[i]) begin
                n_err++; $display("FAIL rr_order[%0d]: gnt=%h want %h", i, gnt, exp_seq[i]); end
            if (i < 4) tick();
        end
        done = 1'b0;
    endtask

    task automatic test_wrap_regrant();
        req = 16'h8000;
        tick();
        n_cmp++; if (gnt !== 16'h8000 || gnt_idx !== 4'd15) begin
            n_err++; $display("FAIL wrap_gnt15: gnt=%h idx=%0d want 8000/15", gnt, gnt_idx); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (gnt !== 16'h8000 || dut.ptr_q !== 4'd0) begin
            n_err++; $display("FAIL wrap_regrant: gnt=%h ptr=%0d want 8000/0", gnt, dut.ptr_q); end
        req = 16'h0;
        tick();
        n_cmp++; if (gnt !== 16'h0 || gnt_valid !== 1'b0) begin
            n_err++; $display("FAIL implicit_release: gnt=%h vld=%b want 0000/0", gnt, gnt_valid); end
    endtask

    task automatic test_mask();
        req  = 16'h0003;
        mask = 16'h0001;
        tick();
        n_cmp++; if (gnt !== 16'h0002 || gnt_idx !== 4'd1) begin
            n_err++; $display("FAIL mask_pick: gnt=%h idx=%0d want 0002/1", gnt, gnt_idx); end
        mask = 16'h0002;
        tick();
        tick();
        n_cmp++; if (gnt !== 16'h0002) begin
            n_err++; $display("FAIL mask_hold: gnt=%h want 0002", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (gnt !== 16'h0001 || timeout !== 1'b0) begin
            n_err++; $display("FAIL mask_handoff: gnt=%h to=%b want 0001/0", gnt, timeout); end
        req  = 16'h0;
        mask = 16'h0;
        tick();
        n_cmp++; if (gnt !== 16'h0 || dut.ptr_q !== 4'd1) begin
            n_err++; $display("FAIL mask_idle: gnt=%h ptr=%0d want 0000/1", gnt, dut.ptr_q); end
    endtask

    task automatic test_timeout();
        req = 16'h0024;
        tick();
        n_cmp++; if (gnt !== 16'h0004 || gnt_idx !== 4'd2) begin
            n_err++; $display("FAIL to_first: gnt=%h idx=%0d want 0004/2", gnt, gnt_idx); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++; if (gnt !== 16'h0004 || timeout !== 1'b0) begin
                n_err++; $display("FAIL to_hold[%0d]: gnt=%h to=%b want 0004/0", i, gnt, timeout); end
        end
        tick();
        n_cmp++; if (gnt !== 16'h0020 || timeout !== 1'b1) begin
            n_err++; $display("FAIL to_expire: gnt=%h to=%b want 0020/1", gnt, timeout); end
        tick();
        n_cmp++; if (gnt !== 16'h0020 || timeout !== 1'b0) begin
            n_err++; $display("FAIL to_pulse_width: gnt=%h to=%b want 0020/0", gnt, timeout); end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (gnt !== 16'h0004 || timeout !== 1'b0) begin
            n_err++; $display("FAIL to_done_coincide: gnt=%h to=%b want 0004/0", gnt, timeout); end
    endtask

    task automatic test_async_reset();
        req = 16'h0400;
        tick();
        n_cmp++; if (gnt !== 16'h0400 || gnt_idx !== 4'd10) begin
            n_err++; $display("FAIL ar_setup: gnt=%h idx=%0d want 0400/10", gnt, gnt_idx); end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (gnt !== 16'h0 || gnt_idx !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL ar_async: gnt=%h idx=%0d vld=%b to=%b want 0/0/0/0", gnt, gnt_idx, gnt_valid, timeout); end
        req = 16'h0402;
        #1;
        resetn = 1'b1;
        tick();
        n_cmp++; if (gnt !== 16'h0002 || gnt_idx !== 4'd1) begin
            n_err++; $display("FAIL ar_ptr0: gnt=%h idx=%0d want 0002/1", gnt, gnt_idx); end
        req = 16'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_regrant();
        test_mask();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
